// File: rtl/glitc_trig_pkg.sv
// glitc_trig_pkg: coincidence-mode encodings and default widths shared by the trigger path.
package glitc_trig_pkg;
   localparam int CORR_BITS    = 12;
   localparam int SCALER_BITS  = 16;
   localparam int GATE_BITS    = 28;
   localparam int HOLDOFF_BITS = 8;
   typedef enum logic [1:0] {
      COINC_R0  = 2'b00,
      COINC_R1  = 2'b01,
      COINC_OR  = 2'b10,
      COINC_AND = 2'b11
   } coinc_mode_e;
endpackage

// File: rtl/corr_discriminator.sv
// corr_discriminator: registered threshold compare with holdoff and a saturating running scaler.
module corr_discriminator #(
   parameter int CORR_BITS    = glitc_trig_pkg::CORR_BITS,
   parameter int SCALER_BITS  = glitc_trig_pkg::SCALER_BITS,
   parameter int HOLDOFF_BITS = glitc_trig_pkg::HOLDOFF_BITS
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_en,
   input  logic                    i_clr,
   input  logic [CORR_BITS-1:0]    i_corr,
   input  logic [CORR_BITS-1:0]    i_thresh,
   input  logic [HOLDOFF_BITS-1:0] i_holdoff,
   output logic                    o_trig,
   output logic [SCALER_BITS-1:0]  o_count
);
   logic [CORR_BITS-1:0]    r_corr, r_thresh;
   logic [HOLDOFF_BITS-1:0] r_hold;
   logic [SCALER_BITS-1:0]  r_run;
   logic                    r_trig, w_fire;
   assign w_fire  = i_en && (r_corr > r_thresh) && (r_hold == '0);
   // count including the event present this cycle, so a gate latch never loses it
   assign o_count = (r_trig && r_run != '1) ? r_run + 1'b1 : r_run;
   assign o_trig  = r_trig;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_corr   <= '0;
         r_thresh <= '0;
         r_hold   <= '0;
         r_run    <= '0;
         r_trig   <= 1'b0;
      end else begin
         r_corr   <= i_corr;
         r_thresh <= i_thresh;
         r_trig   <= w_fire;
         r_hold   <= !i_en ? '0 : w_fire ? i_holdoff : (r_hold != '0) ? r_hold - 1'b1 : '0;
         r_run    <= i_clr ? '0 : o_count;
      end
   end
endmodule

// File: rtl/corr_trigger_scaler.sv
// corr_trigger_scaler: R0/R1 discriminators, coincidence trigger and gated rate scalers
// with latched readout values and a strobe for the register layer.
module corr_trigger_scaler #(
   parameter int CORR_BITS    = glitc_trig_pkg::CORR_BITS,
   parameter int SCALER_BITS  = glitc_trig_pkg::SCALER_BITS,
   parameter int GATE_BITS    = glitc_trig_pkg::GATE_BITS,
   parameter int HOLDOFF_BITS = glitc_trig_pkg::HOLDOFF_BITS
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    enable_i,
   input  logic [CORR_BITS-1:0]    corr_r0_i,
   input  logic [CORR_BITS-1:0]    corr_r1_i,
   input  logic [CORR_BITS-1:0]    thresh_r0_i,
   input  logic [CORR_BITS-1:0]    thresh_r1_i,
   input  logic [HOLDOFF_BITS-1:0] holdoff_i,
   input  logic [1:0]              coinc_mode_i,
   input  logic [GATE_BITS-1:0]    gate_period_i,
   output logic                    trig_r0_o,
   output logic                    trig_r1_o,
   output logic                    trig_o,
   output logic [SCALER_BITS-1:0]  scaler_r0_o,
   output logic [SCALER_BITS-1:0]  scaler_r1_o,
   output logic [SCALER_BITS-1:0]  scaler_trig_o,
   output logic                    scaler_valid_o,
   output logic [7:0]              scaler_seq_o
);
   import glitc_trig_pkg::*;
   logic                   w_term, w_clr, w_coinc, w_trig_r0, w_trig_r1;
   logic [SCALER_BITS-1:0] w_cnt_r0, w_cnt_r1, w_cnt_trig;
   logic [SCALER_BITS-1:0] r_run_trig, r_sc_r0, r_sc_r1, r_sc_trig;
   logic [GATE_BITS-1:0]   r_gate;
   logic [7:0]             r_seq;
   logic                   r_trig, r_valid;
   coinc_mode_e            r_mode;
   // >= rather than == so a period shortened mid-gate ends the gate immediately
   assign w_term = enable_i && (gate_period_i != '0) && (r_gate >= gate_period_i - 1'b1);
   assign w_clr  = w_term || !enable_i;
   corr_discriminator #(.CORR_BITS(CORR_BITS), .SCALER_BITS(SCALER_BITS), .HOLDOFF_BITS(HOLDOFF_BITS)) u_r0 (
      .i_clk(clk_i), .i_rst(rst_i), .i_en(enable_i), .i_clr(w_clr),
      .i_corr(corr_r0_i), .i_thresh(thresh_r0_i), .i_holdoff(holdoff_i),
      .o_trig(w_trig_r0), .o_count(w_cnt_r0)
   );
   corr_discriminator #(.CORR_BITS(CORR_BITS), .SCALER_BITS(SCALER_BITS), .HOLDOFF_BITS(HOLDOFF_BITS)) u_r1 (
      .i_clk(clk_i), .i_rst(rst_i), .i_en(enable_i), .i_clr(w_clr),
      .i_corr(corr_r1_i), .i_thresh(thresh_r1_i), .i_holdoff(holdoff_i),
      .o_trig(w_trig_r1), .o_count(w_cnt_r1)
   );
   always_comb begin
      w_coinc    = (r_mode == COINC_R0) ? w_trig_r0 :
                   (r_mode == COINC_R1) ? w_trig_r1 :
                   (r_mode == COINC_OR) ? (w_trig_r0 | w_trig_r1) : (w_trig_r0 & w_trig_r1);
      w_cnt_trig = (r_trig && r_run_trig != '1) ? r_run_trig + 1'b1 : r_run_trig;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mode     <= COINC_R0;
         r_trig     <= 1'b0;
         r_run_trig <= '0;
         r_gate     <= '0;
         r_valid    <= 1'b0;
         r_seq      <= '0;
         r_sc_r0    <= '0;
         r_sc_r1    <= '0;
         r_sc_trig  <= '0;
      end else begin
         r_mode     <= coinc_mode_e'(coinc_mode_i);
         r_trig     <= w_coinc;
         r_run_trig <= w_clr ? '0 : w_cnt_trig;
         r_gate     <= (w_clr || gate_period_i == '0) ? '0 : r_gate + 1'b1;
         r_valid    <= w_term;
         if (w_term) begin
            r_sc_r0   <= w_cnt_r0;
            r_sc_r1   <= w_cnt_r1;
            r_sc_trig <= w_cnt_trig;
            r_seq     <= r_seq + 1'b1;
         end
      end
   end
   assign trig_r0_o      = w_trig_r0;
   assign trig_r1_o      = w_trig_r1;
   assign trig_o         = r_trig;
   assign scaler_r0_o    = r_sc_r0;
   assign scaler_r1_o    = r_sc_r1;
   assign scaler_trig_o  = r_sc_trig;
   assign scaler_valid_o = r_valid;
   assign scaler_seq_o   = r_seq;
endmodule

// File: tb/tb_corr_trigger_scaler.sv
// tb_corr_trigger_scaler: randomized and directed checks against a window-based reference model.
module tb_corr_trigger_scaler;
   logic        clk_i = 1'b0, rst_i, enable_i;
   logic [11:0] corr_r0_i, corr_r1_i, thresh_r0_i, thresh_r1_i;
   logic [7:0]  holdoff_i;
   logic [1:0]  coinc_mode_i;
   logic [27:0] gate_period_i;
   logic        trig_r0_o, trig_r1_o, trig_o, scaler_valid_o;
   logic [15:0] scaler_r0_o, scaler_r1_o, scaler_trig_o;
   logic [7:0]  scaler_seq_o;

   corr_trigger_scaler dut (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
      .corr_r0_i(corr_r0_i), .corr_r1_i(corr_r1_i),
      .thresh_r0_i(thresh_r0_i), .thresh_r1_i(thresh_r1_i),
      .holdoff_i(holdoff_i), .coinc_mode_i(coinc_mode_i), .gate_period_i(gate_period_i),
      .trig_r0_o(trig_r0_o), .trig_r1_o(trig_r1_o), .trig_o(trig_o),
      .scaler_r0_o(scaler_r0_o), .scaler_r1_o(scaler_r1_o), .scaler_trig_o(scaler_trig_o),
      .scaler_valid_o(scaler_valid_o), .scaler_seq_o(scaler_seq_o)
   );

   always #5 clk_i = ~clk_i;

   localparam int N = 2048;
   int total = 0, bad = 0;
   int th0, th1, hold, mode, per;
   int c0[N], c1[N];
   logic ob_t0[N], ob_t1[N], ob_t[N], ob_v[N];
   logic [15:0] ob_s0[N], ob_s1[N], ob_st[N];
   logic [7:0]  ob_seq[N];
   bit mf0[N], mf1[N];
   bit e_t0[N], e_t1[N], e_t[N], e_v[N];
   int e_s0[N], e_s1[N], e_st[N], e_seq[N];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_stim();
      for (int k = 0; k < N; k++) begin
         c0[k] = 0;
         c1[k] = 0;
      end
   endtask

   // obs k is the state after k+1 edges past the reset edge; input k is applied right after edge k
   task automatic apply_run(input int n);
      rst_i = 1; enable_i = 1; corr_r0_i = 0; corr_r1_i = 0;
      thresh_r0_i = 12'(th0); thresh_r1_i = 12'(th1);
      holdoff_i = 8'(hold); coinc_mode_i = 2'(mode); gate_period_i = 28'(per);
      tick();
      rst_i = 0;
      for (int k = 0; k < n; k++) begin
         corr_r0_i = 12'(c0[k]);
         corr_r1_i = 12'(c1[k]);
         tick();
         ob_t0[k] = trig_r0_o; ob_t1[k] = trig_r1_o; ob_t[k] = trig_o; ob_v[k] = scaler_valid_o;
         ob_s0[k] = scaler_r0_o; ob_s1[k] = scaler_r1_o; ob_st[k] = scaler_trig_o; ob_seq[k] = scaler_seq_o;
      end
   endtask

   // channel trigger visible during cycle c (c edges after reset); ch 2 is the combined trigger
   function automatic bit trg(input int ch, input int c);
      if (ch == 0) return (c >= 2) ? mf0[c-2] : 1'b0;
      if (ch == 1) return (c >= 2) ? mf1[c-2] : 1'b0;
      if (c < 3) return 1'b0;
      case (mode)
         0: return mf0[c-3];
         1: return mf1[c-3];
         2: return mf0[c-3] | mf1[c-3];
         default: return mf0[c-3] & mf1[c-3];
      endcase
   endfunction

   task automatic build_model(input int n);
      int l0 = -1000, l1 = -1000, s0 = 0, s1 = 0, st = 0, seq = 0;
      for (int k = 0; k < n; k++) begin
         mf0[k] = (c0[k] > th0) && (k - l0 > hold);
         mf1[k] = (c1[k] > th1) && (k - l1 > hold);
         if (mf0[k]) l0 = k;
         if (mf1[k]) l1 = k;
      end
      for (int k = 0; k < n; k++) begin
         int c = k + 1;
         e_t0[k] = trg(0, c); e_t1[k] = trg(1, c); e_t[k] = trg(2, c);
         e_v[k] = (per > 0) && (c % per == 0);
         if (e_v[k]) begin
            s0 = 0; s1 = 0; st = 0;
            for (int cc = c - per; cc < c; cc++) begin
               s0 += int'(trg(0, cc)); s1 += int'(trg(1, cc)); st += int'(trg(2, cc));
            end
            s0 = (s0 > 65535) ? 65535 : s0;
            s1 = (s1 > 65535) ? 65535 : s1;
            st = (st > 65535) ? 65535 : st;
            seq = (seq + 1) % 256;
         end
         e_s0[k] = s0; e_s1[k] = s1; e_st[k] = st; e_seq[k] = seq;
      end
   endtask

   task automatic test_reset();
      rst_i = 1; enable_i = 1;
      corr_r0_i = 12'($urandom); corr_r1_i = 12'($urandom);
      thresh_r0_i = 0; thresh_r1_i = 0; holdoff_i = 0; coinc_mode_i = 2'b10; gate_period_i = 3;
      tick(); tick();
      total++;
      if ({trig_r0_o, trig_r1_o, trig_o, scaler_valid_o} !== 4'b0) begin
         bad++; $display("FAIL reset_trig got=%b exp=0000", {trig_r0_o, trig_r1_o, trig_o, scaler_valid_o});
      end
      total++;
      if ({scaler_r0_o, scaler_r1_o, scaler_trig_o} !== 48'd0) begin
         bad++; $display("FAIL reset_scalers got=%0d/%0d/%0d exp=0", scaler_r0_o, scaler_r1_o, scaler_trig_o);
      end
      total++;
      if (scaler_seq_o !== 8'd0) begin
         bad++; $display("FAIL reset_seq got=%0d exp=0", scaler_seq_o);
      end
   endtask

   task automatic test_single_pulse();
      int n0 = 0;
      clear_stim();
      th0 = 100; th1 = 4095; hold = 0; mode = 0; per = 0;
      c0[5] = 101; c0[15] = 100;
      apply_run(30); build_model(30);
      for (int k = 0; k < 30; k++) begin
         n0 += int'(ob_t0[k]);
         total++;
         if (ob_t0[k] !== e_t0[k] || ob_t[k] !== e_t[k]) begin
            bad++; $display("FAIL single_pulse k=%0d got=%b%b exp=%b%b", k, ob_t0[k], ob_t[k], e_t0[k], e_t[k]);
         end
      end
      total++;
      if (ob_t0[6] !== 1'b1 || ob_t[7] !== 1'b1 || n0 != 1) begin
         bad++; $display("FAIL single_pulse_latency t0@6=%b t@7=%b fires=%0d exp=1 1 1", ob_t0[6], ob_t[7], n0);
      end
   endtask

   task automatic test_holdoff();
      for (int h = 0; h <= 3; h += 3) begin
         int n0 = 0;
         clear_stim();
         th0 = 100; th1 = 4095; hold = h; mode = 0; per = 0;
         for (int k = 0; k < 20; k++) c0[k] = 200;
         apply_run(30); build_model(30);
         for (int k = 0; k < 30; k++) begin
            n0 += int'(ob_t0[k]);
            total++;
            if (ob_t0[k] !== e_t0[k]) begin
               bad++; $display("FAIL holdoff h=%0d k=%0d got=%b exp=%b", h, k, ob_t0[k], e_t0[k]);
            end
         end
         total++;
         if (n0 != ((h == 0) ? 20 : 5)) begin
            bad++; $display("FAIL holdoff_count h=%0d got=%0d exp=%0d", h, n0, (h == 0) ? 20 : 5);
         end
      end
   endtask

   task automatic test_coinc();
      for (int m = 2; m <= 3; m++) begin
         int nt = 0;
         clear_stim();
         th0 = 100; th1 = 100; hold = 0; mode = m; per = 0;
         c0[10] = 200; c0[20] = 200; c1[10] = 200; c1[21] = 200;
         apply_run(30); build_model(30);
         for (int k = 0; k < 30; k++) begin
            nt += int'(ob_t[k]);
            total++;
            if (ob_t[k] !== e_t[k]) begin
               bad++; $display("FAIL coinc mode=%0d k=%0d got=%b exp=%b", m, k, ob_t[k], e_t[k]);
            end
         end
         total++;
         if (nt != ((m == 3) ? 1 : 3)) begin
            bad++; $display("FAIL coinc_count mode=%0d got=%0d exp=%0d", m, nt, (m == 3) ? 1 : 3);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         th0 = $urandom_range(40, 4000); th1 = $urandom_range(40, 4000);
         hold = $urandom_range(0, 5); mode = $urandom_range(0, 3); per = $urandom_range(5, 40);
         for (int k = 0; k < 300; k++) begin
            c0[k] = $urandom_range(th0 - 30, th0 + 30);
            c1[k] = $urandom_range(th1 - 30, th1 + 30);
         end
         apply_run(300); build_model(300);
         for (int k = 0; k < 300; k++) begin
            total++;
            if ({ob_t0[k], ob_t1[k], ob_t[k], ob_v[k]} !== {e_t0[k], e_t1[k], e_t[k], e_v[k]}) begin
               bad++; $display("FAIL random_trig it=%0d k=%0d got=%b%b%b%b exp=%b%b%b%b", it, k,
                               ob_t0[k], ob_t1[k], ob_t[k], ob_v[k], e_t0[k], e_t1[k], e_t[k], e_v[k]);
            end
            total++;
            if (ob_s0[k] !== 16'(e_s0[k]) || ob_s1[k] !== 16'(e_s1[k]) || ob_st[k] !== 16'(e_st[k]) || ob_seq[k] !== 8'(e_seq[k])) begin
               bad++; $display("FAIL random_scalers it=%0d k=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", it, k,
                               ob_s0[k], ob_s1[k], ob_st[k], ob_seq[k], e_s0[k], e_s1[k], e_st[k], e_seq[k]);
            end
         end
      end
   endtask

   task automatic test_gating();
      int nstb = 0;
      clear_stim();
      th0 = 100; th1 = 4095; hold = 0; mode = 0; per = 50;
      for (int k = 0; k < 160; k++) begin
         int o = (k + 2) % 50;
         if (o == 3 || o == 5 || o == 12 || o == 20 || o == 33 || o == 41 || o == 49) c0[k] = 200;
      end
      apply_run(151); build_model(151);
      for (int k = 0; k < 151; k++) begin
         total++;
         if (ob_v[k] !== e_v[k] || ob_s0[k] !== 16'(e_s0[k]) || ob_seq[k] !== 8'(e_seq[k])) begin
            bad++; $display("FAIL gating k=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", k, ob_v[k], ob_s0[k], ob_seq[k], e_v[k], e_s0[k], e_seq[k]);
         end
         if (ob_v[k] === 1'b1) begin
            nstb++;
            total++;
            if (ob_s0[k] !== 16'd7 || ob_seq[k] !== 8'(nstb)) begin
               bad++; $display("FAIL gating_strobe n=%0d got=%0d/%0d exp=7/%0d", nstb, ob_s0[k], ob_seq[k], nstb);
            end
         end
      end
      total++;
      if (nstb != 3) begin
         bad++; $display("FAIL gating_strobes got=%0d exp=3", nstb);
      end
   endtask

   task automatic test_seq_wrap();
      clear_stim();
      th0 = 100; th1 = 100; hold = 0; mode = 0; per = 2;
      apply_run(520); build_model(520);
      for (int k = 0; k < 520; k++) begin
         total++;
         if (ob_v[k] !== e_v[k] || ob_seq[k] !== 8'(e_seq[k])) begin
            bad++; $display("FAIL seq_wrap k=%0d got=%b/%0d exp=%b/%0d", k, ob_v[k], ob_seq[k], e_v[k], e_seq[k]);
         end
      end
      total++;
      if (ob_seq[509] !== 8'd255 || ob_seq[511] !== 8'd0 || ob_v[511] !== 1'b1) begin
         bad++; $display("FAIL seq_wrap_256 got=%0d,%0d,%b exp=255,0,1", ob_seq[509], ob_seq[511], ob_v[511]);
      end
   endtask

   task automatic test_saturation();
      int at = 0;
      rst_i = 1; enable_i = 1; corr_r0_i = 4095; corr_r1_i = 0;
      thresh_r0_i = 100; thresh_r1_i = 4095; holdoff_i = 0; coinc_mode_i = 0; gate_period_i = 70000;
      tick();
      rst_i = 0;
      for (int m = 1; m <= 70100 && at == 0; m++) begin
         tick();
         if (scaler_valid_o === 1'b1) at = m;
      end
      total++;
      if (at != 70000) begin
         bad++; $display("FAIL sat_strobe_cycle got=%0d exp=70000", at);
      end
      total++;
      if (scaler_r0_o !== 16'hFFFF || scaler_trig_o !== 16'hFFFF || scaler_r1_o !== 16'd0 || scaler_seq_o !== 8'd1) begin
         bad++; $display("FAIL sat_values got=%0d/%0d/%0d/%0d exp=65535/65535/0/1", scaler_r0_o, scaler_trig_o, scaler_r1_o, scaler_seq_o);
      end
   endtask

   task automatic test_controls();
      clear_stim();
      th0 = 100; th1 = 100; hold = 0; mode = 2; per = 0;
      for (int k = 0; k < 120; k++) begin
         c0[k] = $urandom_range(0, 200);
         c1[k] = $urandom_range(0, 200);
      end
      apply_run(120);
      for (int k = 0; k < 120; k++) begin
         total++;
         if (ob_v[k] !== 1'b0 || ob_s0[k] !== 16'd0 || ob_seq[k] !== 8'd0) begin
            bad++; $display("FAIL period0 k=%0d got=%b/%0d/%0d exp=0/0/0", k, ob_v[k], ob_s0[k], ob_seq[k]);
         end
      end
      rst_i = 1; enable_i = 1; corr_r0_i = 4095; corr_r1_i = 0;
      thresh_r0_i = 100; thresh_r1_i = 4095; holdoff_i = 0; coinc_mode_i = 0; gate_period_i = 20;
      tick();
      rst_i = 0;
      for (int m = 1; m <= 20; m++) begin
         tick();
         total++;
         if (scaler_valid_o !== (m == 20)) begin
            bad++; $display("FAIL gate1_strobe m=%0d got=%b exp=%b", m, scaler_valid_o, m == 20);
         end
      end
      total++;
      if (scaler_r0_o !== 16'd18 || scaler_trig_o !== 16'd17 || scaler_seq_o !== 8'd1) begin
         bad++; $display("FAIL gate1_values got=%0d/%0d/%0d exp=18/17/1", scaler_r0_o, scaler_trig_o, scaler_seq_o);
      end
      repeat (5) tick();
      enable_i = 0;
      for (int m = 1; m <= 10; m++) begin
         tick();
         total++;
         if (scaler_valid_o !== 1'b0 || scaler_r0_o !== 16'd18 || scaler_seq_o !== 8'd1) begin
            bad++; $display("FAIL disabled_hold m=%0d got=%b/%0d/%0d exp=0/18/1", m, scaler_valid_o, scaler_r0_o, scaler_seq_o);
         end
      end
      enable_i = 1;
      for (int m = 1; m <= 20; m++) begin
         tick();
         total++;
         if (scaler_valid_o !== (m == 20)) begin
            bad++; $display("FAIL reenable_strobe m=%0d got=%b exp=%b", m, scaler_valid_o, m == 20);
         end
      end
      total++;
      if (scaler_r0_o !== 16'd19 || scaler_trig_o !== 16'd18 || scaler_seq_o !== 8'd2) begin
         bad++; $display("FAIL reenable_values got=%0d/%0d/%0d exp=19/18/2", scaler_r0_o, scaler_trig_o, scaler_seq_o);
      end
      repeat (7) tick();
      rst_i = 1;
      tick();
      rst_i = 0;
      total++;
      if ({trig_r0_o, trig_r1_o, trig_o, scaler_valid_o, scaler_r0_o, scaler_r1_o, scaler_trig_o, scaler_seq_o} !== '0) begin
         bad++; $display("FAIL midgate_reset got=%b%b%b%b/%0d/%0d/%0d/%0d exp=all 0", trig_r0_o, trig_r1_o, trig_o,
                         scaler_valid_o, scaler_r0_o, scaler_r1_o, scaler_trig_o, scaler_seq_o);
      end
      for (int m = 1; m <= 20; m++) begin
         tick();
         total++;
         if (scaler_valid_o !== (m == 20)) begin
            bad++; $display("FAIL post_reset_strobe m=%0d got=%b exp=%b", m, scaler_valid_o, m == 20);
         end
      end
      total++;
      if (scaler_r0_o !== 16'd18 || scaler_seq_o !== 8'd1) begin
         bad++; $display("FAIL post_reset_values got=%0d/%0d exp=18/1", scaler_r0_o, scaler_seq_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_holdoff();
      test_coinc();
      test_random();
      test_gating();
      test_seq_wrap();
      test_controls();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/corr_trigger_scaler.md
Name: corr_trigger_scaler

Overview:
- Sits directly downstream of the two single-correlation stages (R0 and R1) in the SYSCLK domain.
- Discriminates each 12-bit correlation output against a programmable threshold, with per-channel holdoff.
- Forms a combined trigger per a coincidence mode.
- Accumulates gated rate scalers. Latched scaler values and a valid strobe are handed to the control-register layer for GLITCBUS readout.

Parameters:
- CORR_BITS, 12, width of correlation inputs and thresholds (unsigned).
- SCALER_BITS, 16, width of each scaler (saturating).
- GATE_BITS, 28, width of gate-period counter (1 s at 162.5 MHz fits).
- HOLDOFF_BITS, 8, width of holdoff counters.

Ports:
- clk_i  in  1  SYSCLK (162.5 MHz); sole clock.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  global enable.
- corr_r0_i  in  CORR_BITS  R0 correlation value, new each cycle.
- corr_r1_i  in  CORR_BITS  R1 correlation value, new each cycle.
- thresh_r0_i  in  CORR_BITS  R0 threshold, quasi-static.
- thresh_r1_i  in  CORR_BITS  R1 threshold, quasi-static.
- holdoff_i  in  HOLDOFF_BITS  dead cycles after a channel fire.
- coinc_mode_i  in  2  00 = R0, 01 = R1, 10 = OR, 11 = AND.
- gate_period_i  in  GATE_BITS  gate length in clk_i cycles; 0 = gating halted.
- trig_r0_o  out  1  R0 discriminator fire.
- trig_r1_o  out  1  R1 discriminator fire.
- trig_o  out  1  combined trigger.
- scaler_r0_o  out  SCALER_BITS  latched R0 count of last gate.
- scaler_r1_o  out  SCALER_BITS  latched R1 count.
- scaler_trig_o  out  SCALER_BITS  latched trig_o count.
- scaler_valid_o  out  1  one-cycle strobe when latched scalers update.
- scaler_seq_o  out  8  gate sequence number, increments with each strobe, wraps 255 -> 0.

Behaviour:
- Reset: all outputs, holdoff counters, running scalers, gate counter and sequence counter go to 0.
- Stage 1: corr and thresh inputs registered.
- Stage 2, per channel: fire = enable_i & (corr > thresh), strict greater-than, & (holdoff_cnt == 0). trig_rX_o is registered fire.
  - Channel latency: corr at edge N -> trig_rX_o high after edge N+2.
- Holdoff:
  - On fire, holdoff_cnt loads holdoff_i.
  - Otherwise it decrements while nonzero.
  - holdoff_i = 0 allows a fire every cycle.
  - holdoff_i = H gives minimum fire spacing H+1 cycles.
- Combined trigger: trig_o registered from trig_r0_o/trig_r1_o per coinc_mode_i. Latency 3 cycles from corr.
  - AND requires both channel fires in the same cycle; there is no window.
- Running scalers increment on trig_r0_o, trig_r1_o and trig_o respectively. They saturate at all-ones and never wrap.
- Gate counter:
  - Increments each cycle when enable_i = 1 and gate_period_i != 0.
  - Terminal when count >= gate_period_i - 1, so a period reduced mid-gate terminates on the next cycle.
- At the terminal cycle:
  - Latched scalers take running count plus any event in that same cycle (saturated).
  - Running scalers and gate counter clear to 0.
  - scaler_valid_o pulses high on the next cycle, coincident with the new latched values.
  - scaler_seq_o increments.
- gate_period_i = 0: gate counter holds at 0, no strobes; running scalers keep counting (saturating); latched outputs hold.
- enable_i = 0:
  - No fires; holdoff counters, running scalers and gate counter forced to 0.
  - Latched outputs and scaler_seq_o hold.
  - Triggers already in the pipeline still complete.
- Threshold or mode changes take effect with the stage-1 register, so 1 cycle later. No glitch protection beyond that is required.
- rst_i mid-gate discards the partial gate; no strobe is generated.

Decomposition:
- Shared package glitc_trig_pkg holds:
  - coincidence-mode encodings (COINC_R0, COINC_R1, COINC_OR, COINC_AND);
  - default widths (CORR_BITS, SCALER_BITS, GATE_BITS, HOLDOFF_BITS).
- One sub-module, corr_discriminator: threshold compare, holdoff counter, saturating running scaler. Instantiated twice.
- The top handles coincidence, the trig scaler, gate timing and latching.

Test Plan:
- Single pulse:
  - Setup: thresh_r0 = 100, holdoff = 0, mode 00; corr_r0 = 101 for 1 cycle at edge N.
  - Required: trig_r0_o high exactly after edge N+2; trig_o high after edge N+3.
  - Also: corr_r0 = 100 produces no fire.
- Holdoff:
  - Setup: holdoff = 3; corr_r0 above threshold continuously for 20 cycles.
  - Required: fires every 4th cycle, 5 fires total; holdoff = 0 gives 20 consecutive fires.
- Coincidence, mode 11:
  - Stimulus: R0 fires cycles {10, 20}, R1 fires {10, 21}.
  - Required: trig_o once (cycle 10 path).
  - Mode 10 with the same stimulus: trig_o 3 times.
- Gating:
  - Setup: gate_period = 50, R0 fires 7 times per gate, including one in the terminal cycle.
  - Required: scaler_valid_o every 50 cycles, scaler_r0_o = 7; seq increments 0 -> 1 -> 2.
  - Also: 256 gates wrap scaler_seq_o to 0.
- Saturation:
  - Setup: SCALER_BITS = 16, gate_period = 70000, R0 fires every cycle.
  - Required: scaler_r0_o = 65535.
- Controls mid-operation:
  - gate_period 0 -> no strobes.
  - enable_i low mid-gate -> running counts cleared, latched values held.
  - rst_i mid-gate -> all outputs 0, next strobe exactly gate_period cycles after reset release.
